// File: rtl/mc_controller_pkg.sv
// Shared control definitions for the multicycle ARM-subset core: FSM states,
// ALU operation codes, datapath select constants and the condition table.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER,
    EXECUTEI, ALUWB, BRANCH, MULEX, MULWBLO, MULWBHI, MULWB
  } state_t;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_ORR   = 4'b0011;
  localparam logic [3:0] ALU_EOR   = 4'b0100;
  localparam logic [3:0] ALU_MOV   = 4'b0101;
  localparam logic [3:0] ALU_MUL   = 4'b0110;
  localparam logic [3:0] ALU_UMULL = 4'b0111;
  localparam logic [3:0] ALU_SMULL = 4'b1000;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_REG = 2'b00;
  localparam logic [1:0] SRCA_PC  = 2'b01;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_EXTIMM = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  // Standard ARM condition table; 1111 never executes.
  function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      4'h0: cond_check = z;
      4'h1: cond_check = !z;
      4'h2: cond_check = c;
      4'h3: cond_check = !c;
      4'h4: cond_check = n;
      4'h5: cond_check = !n;
      4'h6: cond_check = v;
      4'h7: cond_check = !v;
      4'h8: cond_check = c && !z;
      4'h9: cond_check = !c || z;
      4'hA: cond_check = (n == v);
      4'hB: cond_check = (n != v);
      4'hC: cond_check = !z && (n == v);
      4'hD: cond_check = z || (n != v);
      4'hE: cond_check = 1'b1;
      default: cond_check = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath bundle: instruction and flags in, selects/enables out.
interface mc_controller_if;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite;
  logic        MemWrite;
  logic        RegWrite;
  logic        IRWrite;
  logic        AdrSrc;
  logic [1:0]  RegSrc;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ResultSrc;
  logic [1:0]  ImmSrc;
  logic [3:0]  ALUControl;
  logic        isMul;
  logic        longFlag;

  modport master (
    input  Instr, ALUFlags,
    output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA,
           ALUSrcB, ResultSrc, ImmSrc, ALUControl, isMul, longFlag
  );

  modport slave (
    output Instr, ALUFlags,
    input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA,
           ALUSrcB, ResultSrc, ImmSrc, ALUControl, isMul, longFlag
  );
endinterface

// File: rtl/mc_controller_cond_unit.sv
// NZCV flag register and condition evaluation against the registered flags.
module cond_unit
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond_i,
  input  logic [3:0] alu_flags_i,
  input  logic       flag_we_i,
  input  logic       nz_only_i,
  output logic       condex_o
);

  logic [3:0] nzcv_q;

  // Logical ops and multiplies leave C and V untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      nzcv_q <= 4'b0000;
    end else if (flag_we_i) begin
      nzcv_q[3:2] <= alu_flags_i[3:2];
      if (!nz_only_i) nzcv_q[1:0] <= alu_flags_i[1:0];
    end
  end

  assign condex_o = cond_check(cond_i, nzcv_q);

endmodule

// File: rtl/mc_controller.sv
// Multicycle control unit: main Moore FSM, instruction decode and write gating
// of every architectural update by the instruction's condition result.
module mc_controller
  import ctrl_pkg::*;
#(
  parameter state_t RESET_STATE = FETCH
) (
  input logic clk,
  input logic reset,
  mc_controller_if.master bus
);

  state_t      state_q;
  logic        exec_ok_q;
  logic        condex;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic        is_mul_dec, is_long;
  logic [3:0]  dp_alu, mul_alu;
  logic        dp_nowrite, dp_nz_only;
  logic        rd_is_pc;
  logic        pc_we, mem_we, reg_we, ir_we, long_flag, adr_src, is_mul;
  logic [1:0]  reg_src, src_a, src_b, res_src;
  logic [3:0]  alu_ctl;
  logic        flag_we;
  logic        unused_instr_bits;

  assign op         = bus.Instr[27:26];
  assign funct      = bus.Instr[25:20];
  assign is_mul_dec = (op == 2'b00) && (bus.Instr[25:24] == 2'b00) && (bus.Instr[7:4] == 4'b1001);
  assign is_long    = bus.Instr[23];
  assign rd_is_pc   = (bus.Instr[15:12] == 4'hF);
  assign mul_alu    = !is_long ? ALU_MUL : (bus.Instr[22] ? ALU_SMULL : ALU_UMULL);
  assign unused_instr_bits = ^{bus.Instr[19:16], bus.Instr[11:8], bus.Instr[3:0]};

  always_comb begin
    dp_alu     = ALU_ADD;
    dp_nowrite = 1'b0;
    dp_nz_only = 1'b0;
    case (funct[4:1])
      4'b0100: dp_alu = ALU_ADD;
      4'b0010: dp_alu = ALU_SUB;
      4'b0000: begin dp_alu = ALU_AND; dp_nz_only = 1'b1; end
      4'b1100: begin dp_alu = ALU_ORR; dp_nz_only = 1'b1; end
      4'b0001: begin dp_alu = ALU_EOR; dp_nz_only = 1'b1; end
      4'b1010: begin dp_alu = ALU_SUB; dp_nowrite = 1'b1; end
      4'b1101: begin dp_alu = ALU_MOV; dp_nz_only = 1'b1; end
      default: begin dp_alu = ALU_ADD; dp_nowrite = 1'b1; end
    endcase
  end

  assign flag_we = (state_q == EXECUTER || state_q == EXECUTEI || state_q == MULEX)
                   && funct[0] && condex && !reset;

  cond_unit u_cond (
    .clk         (clk),
    .reset       (reset),
    .cond_i      (bus.Instr[31:28]),
    .alu_flags_i (bus.ALUFlags),
    .flag_we_i   (flag_we),
    .nz_only_i   ((state_q == MULEX) || dp_nz_only),
    .condex_o    (condex)
  );

  // Condition is captured in DECODE so later write-back states are not
  // affected by flags this same instruction updates at the end of execute.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RESET_STATE;
      exec_ok_q <= 1'b0;
    end else begin
      if (state_q == DECODE) exec_ok_q <= condex;
      case (state_q)
        FETCH:    state_q <= DECODE;
        DECODE: begin
          if (op == 2'b01)      state_q <= MEMADR;
          else if (op == 2'b10) state_q <= BRANCH;
          else if (op == 2'b11) state_q <= FETCH;
          else if (is_mul_dec)  state_q <= MULEX;
          else if (funct[5])    state_q <= EXECUTEI;
          else                  state_q <= EXECUTER;
        end
        MEMADR:   state_q <= bus.Instr[20] ? MEMREAD : MEMWRITE;
        MEMREAD:  state_q <= MEMWB;
        EXECUTER, EXECUTEI: state_q <= ALUWB;
        MULEX:    state_q <= is_long ? MULWBLO : MULWB;
        MULWBLO:  state_q <= MULWBHI;
        default:  state_q <= FETCH;
      endcase
    end
  end

  always_comb begin
    pc_we = 1'b0; mem_we = 1'b0; reg_we = 1'b0; ir_we = 1'b0;
    long_flag = 1'b0; adr_src = 1'b0; is_mul = 1'b0;
    reg_src = 2'b00; src_a = SRCA_REG; src_b = SRCB_REG; res_src = RES_ALUOUT;
    alu_ctl = ALU_ADD;
    case (state_q)
      FETCH: begin
        ir_we = 1'b1; pc_we = 1'b1;
        src_a = SRCA_PC; src_b = SRCB_FOUR; res_src = RES_ALURESULT;
      end
      DECODE: begin
        src_a = SRCA_PC; src_b = SRCB_FOUR; res_src = RES_ALURESULT;
        reg_src = {op == 2'b01, op == 2'b10};
      end
      MEMADR: begin
        src_b = SRCB_EXTIMM;
        alu_ctl = bus.Instr[23] ? ALU_ADD : ALU_SUB;
      end
      MEMREAD:  adr_src = 1'b1;
      MEMWB: begin
        res_src = RES_DATA; reg_we = exec_ok_q;
        pc_we = exec_ok_q && rd_is_pc;
      end
      MEMWRITE: begin adr_src = 1'b1; mem_we = exec_ok_q; end
      EXECUTER: alu_ctl = dp_alu;
      EXECUTEI: begin src_b = SRCB_EXTIMM; alu_ctl = dp_alu; end
      ALUWB: begin
        reg_we = exec_ok_q && !dp_nowrite;
        pc_we  = exec_ok_q && !dp_nowrite && rd_is_pc;
      end
      BRANCH: begin
        reg_src = 2'b01; src_b = SRCB_EXTIMM; res_src = RES_ALURESULT;
        pc_we = exec_ok_q;
      end
      MULEX:    begin is_mul = 1'b1; alu_ctl = mul_alu; end
      MULWBLO:  begin is_mul = 1'b1; long_flag = exec_ok_q; end
      MULWBHI, MULWB: begin is_mul = 1'b1; reg_we = exec_ok_q; end
      default: ;
    endcase
  end

  assign bus.PCWrite    = pc_we && !reset;
  assign bus.MemWrite   = mem_we && !reset;
  assign bus.RegWrite   = reg_we && !reset;
  assign bus.IRWrite    = ir_we && !reset;
  assign bus.longFlag   = long_flag && !reset;
  assign bus.AdrSrc     = adr_src;
  assign bus.RegSrc     = reg_src;
  assign bus.ALUSrcA    = src_a;
  assign bus.ALUSrcB    = src_b;
  assign bus.ResultSrc  = res_src;
  assign bus.ImmSrc     = op;
  assign bus.ALUControl = alu_ctl;
  assign bus.isMul      = is_mul;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks instruction sequences state by state.
module tb_mc_controller;
  import ctrl_pkg::*;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  mc_controller_if bus();

  mc_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input state_t exp);
    chk(tag, 32'(dut.state_q), 32'(exp));
  endtask

  initial begin
    reset = 1'b1;
    bus.Instr = 32'h0;
    bus.ALUFlags = 4'b0000;
    cyc();
    chk_state("rst_state", FETCH);
    chk("rst_pcwrite", 32'(bus.PCWrite), 32'd0);
    chk("rst_irwrite", 32'(bus.IRWrite), 32'd0);
    chk("rst_nzcv", 32'(dut.u_cond.nzcv_q), 32'd0);

    // ADD R1,R2,#5
    reset = 1'b0;
    bus.Instr = 32'hE2821005;
    #1;
    chk("add_f_irwrite", 32'(bus.IRWrite), 32'd1);
    chk("add_f_pcwrite", 32'(bus.PCWrite), 32'd1);
    chk("add_f_srca", 32'(bus.ALUSrcA), 32'd1);
    chk("add_f_srcb", 32'(bus.ALUSrcB), 32'd2);
    chk("add_f_res", 32'(bus.ResultSrc), 32'd2);
    chk("add_immsrc", 32'(bus.ImmSrc), 32'd0);
    chk("add_f_regwrite", 32'(bus.RegWrite), 32'd0);
    cyc();
    chk_state("add_dec", DECODE);
    chk("add_d_regwrite", 32'(bus.RegWrite), 32'd0);
    cyc();
    chk_state("add_exi", EXECUTEI);
    chk("add_e_srcb", 32'(bus.ALUSrcB), 32'd1);
    chk("add_e_alu", 32'(bus.ALUControl), 32'(ALU_ADD));
    chk("add_e_regwrite", 32'(bus.RegWrite), 32'd0);
    cyc();
    chk_state("add_wb", ALUWB);
    chk("add_wb_regwrite", 32'(bus.RegWrite), 32'd1);
    chk("add_wb_pcwrite", 32'(bus.PCWrite), 32'd0);
    cyc();
    chk_state("add_back", FETCH);
    chk("add_back_regwrite", 32'(bus.RegWrite), 32'd0);

    // SUBS R0,R0,R0 -> Z and C set
    bus.Instr = 32'hE0500000;
    cyc();
    cyc();
    bus.ALUFlags = 4'b0110;
    #1;
    chk_state("subs_exr", EXECUTER);
    chk("subs_alu", 32'(bus.ALUControl), 32'(ALU_SUB));
    chk("subs_srcb", 32'(bus.ALUSrcB), 32'd0);
    cyc();
    chk("subs_nzcv", 32'(dut.u_cond.nzcv_q), 32'h6);
    chk("subs_regwrite", 32'(bus.RegWrite), 32'd1);
    cyc();

    // ADDEQ R3,R3,#1 with Z=1
    bus.Instr = 32'h02833001;
    bus.ALUFlags = 4'b0000;
    cyc();
    cyc();
    chk("addeq_e_regwrite", 32'(bus.RegWrite), 32'd0);
    cyc();
    chk("addeq_wb_regwrite", 32'(bus.RegWrite), 32'd1);
    cyc();

    // ADDNE R3,R3,#1 with Z=1: nothing written
    bus.Instr = 32'h12833001;
    #1;
    chk("addne_f_regwrite", 32'(bus.RegWrite), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk($sformatf("addne_c%0d_regwrite", i), 32'(bus.RegWrite), 32'd0);
    end
    chk_state("addne_back", FETCH);

    // BNE with Z=1: not taken
    bus.Instr = 32'h1A000002;
    cyc();
    chk("bne1_d_regsrc", 32'(bus.RegSrc), 32'd1);
    cyc();
    chk_state("bne1_br", BRANCH);
    chk("bne1_pcwrite", 32'(bus.PCWrite), 32'd0);
    cyc();

    // ANDS R0,R0,R0: N,Z from ALU, C,V held
    bus.Instr = 32'hE0100000;
    cyc();
    cyc();
    bus.ALUFlags = 4'b1011;
    #1;
    chk("ands_alu", 32'(bus.ALUControl), 32'(ALU_AND));
    cyc();
    chk("ands_nzcv", 32'(dut.u_cond.nzcv_q), 32'hA);
    bus.ALUFlags = 4'b0000;
    cyc();

    // BNE with Z=0: taken
    bus.Instr = 32'h1A000002;
    cyc();
    cyc();
    chk_state("bne0_br", BRANCH);
    chk("bne0_pcwrite", 32'(bus.PCWrite), 32'd1);
    chk("bne0_res", 32'(bus.ResultSrc), 32'd2);
    chk("bne0_regsrc", 32'(bus.RegSrc), 32'd1);
    chk("bne0_srcb", 32'(bus.ALUSrcB), 32'd1);
    cyc();

    // LDR R4,[R5,#8]
    bus.Instr = 32'hE5954008;
    cyc();
    chk("ldr_d_regsrc", 32'(bus.RegSrc), 32'd2);
    cyc();
    chk_state("ldr_adr", MEMADR);
    chk("ldr_adr_srcb", 32'(bus.ALUSrcB), 32'd1);
    chk("ldr_adr_alu", 32'(bus.ALUControl), 32'(ALU_ADD));
    cyc();
    chk_state("ldr_rd", MEMREAD);
    chk("ldr_rd_adrsrc", 32'(bus.AdrSrc), 32'd1);
    chk("ldr_rd_res", 32'(bus.ResultSrc), 32'd0);
    cyc();
    chk_state("ldr_wb", MEMWB);
    chk("ldr_wb_regwrite", 32'(bus.RegWrite), 32'd1);
    chk("ldr_wb_res", 32'(bus.ResultSrc), 32'd1);
    chk("ldr_wb_pcwrite", 32'(bus.PCWrite), 32'd0);
    cyc();
    chk_state("ldr_back", FETCH);

    // STR R4,[R5,#8]
    bus.Instr = 32'hE5854008;
    cyc();
    chk("str_d_regsrc", 32'(bus.RegSrc), 32'd2);
    cyc();
    chk("str_adr_memwrite", 32'(bus.MemWrite), 32'd0);
    cyc();
    chk_state("str_wr", MEMWRITE);
    chk("str_wr_memwrite", 32'(bus.MemWrite), 32'd1);
    chk("str_wr_adrsrc", 32'(bus.AdrSrc), 32'd1);
    cyc();
    chk("str_back_memwrite", 32'(bus.MemWrite), 32'd0);

    // UMULL R2,R3,R4,R5
    bus.Instr = 32'hE0832594;
    cyc();
    cyc();
    chk_state("umull_ex", MULEX);
    chk("umull_ex_ismul", 32'(bus.isMul), 32'd1);
    chk("umull_ex_alu", 32'(bus.ALUControl), 32'(ALU_UMULL));
    chk("umull_ex_long", 32'(bus.longFlag), 32'd0);
    cyc();
    chk_state("umull_lo", MULWBLO);
    chk("umull_lo_long", 32'(bus.longFlag), 32'd1);
    chk("umull_lo_ismul", 32'(bus.isMul), 32'd1);
    chk("umull_lo_regwrite", 32'(bus.RegWrite), 32'd0);
    cyc();
    chk_state("umull_hi", MULWBHI);
    chk("umull_hi_regwrite", 32'(bus.RegWrite), 32'd1);
    chk("umull_hi_ismul", 32'(bus.isMul), 32'd1);
    chk("umull_hi_long", 32'(bus.longFlag), 32'd0);
    cyc();
    chk("umull_back_ismul", 32'(bus.isMul), 32'd0);

    // Cond=1111 never executes
    bus.Instr = 32'hF2821005;
    cyc();
    cyc();
    cyc();
    chk_state("nv_wb", ALUWB);
    chk("nv_wb_regwrite", 32'(bus.RegWrite), 32'd0);
    cyc();

    // Reset in the middle of MEMWRITE
    bus.Instr = 32'hE5854008;
    cyc();
    cyc();
    cyc();
    chk_state("rstmid_wr", MEMWRITE);
    reset = 1'b1;
    #1;
    chk("rstmid_memwrite", 32'(bus.MemWrite), 32'd0);
    cyc();
    chk_state("rstmid_state", FETCH);
    chk("rstmid_nzcv", 32'(dut.u_cond.nzcv_q), 32'd0);
    chk("rstmid_pcwrite", 32'(bus.PCWrite), 32'd0);
    reset = 1'b0;
    #1;
    chk("rstmid_irwrite", 32'(bus.IRWrite), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Control unit for the multicycle ARM-subset core; sits directly upstream of the datapath and drives every datapath select and enable from the fetched instruction and the ALU flags.
- Contains the main Moore FSM, an instruction decoder (data-processing, LDR/STR, B, MUL/UMULL/SMULL), the NZCV flag register and condition-check logic.
- Gates all architectural writes (registers, memory, PC on branch) with the condition-check result.

Parameters:
- RESET_STATE, FETCH, state the FSM enters on reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- Instr  in  32  instruction register contents from the datapath.
- ALUFlags  in  4  {N,Z,C,V} from the ALU, same cycle.
- PCWrite  out  1  PC register enable.
- MemWrite  out  1  data memory write strobe.
- RegWrite  out  1  register file port-3 write enable.
- IRWrite  out  1  instruction register enable.
- AdrSrc  out  1  0: address = PC; 1: address = Result.
- RegSrc  out  2  [0]=1: RA1=R15; [1]=1: RA2=Instr[15:12].
- ALUSrcA  out  2  00: A; 01: PC.
- ALUSrcB  out  2  00: register; 01: ExtImm; 10: constant 4.
- ResultSrc  out  2  00: ALUOut; 01: Data; 10: ALUResult.
- ImmSrc  out  2  equals Instr[27:26].
- ALUControl  out  4  ALU operation code from the shared package.
- isMul  out  1  current instruction is MUL/UMULL/SMULL.
- longFlag  out  1  long-multiply low-word write / high-word capture strobe.

Behaviour:
- Reset:
  - One clk edge with reset=1 loads state=FETCH and NZCV=0000.
  - While reset=1, PCWrite, MemWrite, RegWrite, IRWrite and longFlag are forced to 0.
- Decode fields: Cond=Instr[31:28], Op=Instr[27:26], Funct=Instr[25:20], S=Instr[20].
  - isMul = (Op==00 && Instr[25:24]==00 && Instr[7:4]==1001).
  - Long multiply = isMul && Instr[23]; signed when Instr[22]=1.
- CondEx is combinational from Cond and the registered NZCV.
  - Uses the standard ARM table for EQ..LE and AL (1110).
  - Cond=1111 is never executed.
- States and outputs. Unlisted outputs are 0 and unlisted selects are 00; ALUControl is ADD unless stated.
  - FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, PCWrite=1 (unconditional). Next: DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10; RegSrc from decode. Next state by decode:
    - Op=01: MEMADR.
    - Op=10: BRANCH.
    - isMul: MULEX.
    - Op=00 with Funct[5]=1: EXECUTEI.
    - Op=00 otherwise: EXECUTER.
    - Op=11: FETCH (treated as NOP).
  - MEMADR: ALUSrcB=01; ALUControl=ADD if Instr[23]=1 else SUB. Next: MEMREAD if Instr[20]=1, else MEMWRITE.
  - MEMREAD: AdrSrc=1, ResultSrc=00. Next: MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=CondEx. Next: FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=CondEx. Next: FETCH.
  - EXECUTER: ALUSrcB=00. Next: ALUWB.
  - EXECUTEI: ALUSrcB=01. Next: ALUWB.
    - In both, ALUControl decodes Funct[4:1]: ADD 0100, SUB 0010, AND 0000, ORR 1100, EOR 0001, CMP 1010 (SUB, no write), MOV 1101.
    - Other Funct[4:1] codes execute as ADD with RegWrite suppressed.
  - ALUWB: ResultSrc=00, RegWrite=CondEx && !CMP. Next: FETCH.
  - BRANCH: RegSrc[0]=1, ALUSrcB=01, ResultSrc=10, PCWrite=CondEx. Next: FETCH.
  - MULEX: isMul=1; ALUControl = MUL, UMULL or SMULL. Next: MULWB (32-bit) or MULWBLO (long).
  - MULWBLO: isMul=1, ResultSrc=00, longFlag=CondEx. Writes RdLo=Instr[15:12]; ALUOut captures the high word. Next: MULWBHI.
  - MULWBHI: isMul=1, ResultSrc=00, RegWrite=CondEx. Writes RdHi=Instr[19:16]. Next: FETCH.
  - MULWB: isMul=1, ResultSrc=00, RegWrite=CondEx. Next: FETCH.
- isMul is held through all MUL states so the datapath register addressing stays stable.
- PC as destination: in MEMWB and ALUWB, if Instr[15:12]==15 and CondEx, PCWrite=1 in the same cycle as RegWrite.
- Flags:
  - NZCV updates at the end of EXECUTER, EXECUTEI and MULEX when S=1 and CondEx.
  - Logical ops and MUL update only N and Z; C and V are held.
  - CondEx in that cycle uses the old NZCV.
- A failed condition still walks the full state sequence; only the write enables are suppressed.
- Reset asserted in any state returns to FETCH on the next edge; no partial write completes.

Decomposition:
- Package ctrl_pkg holds:
  - the state enum (4-bit encoding);
  - ALUControl localparams: ADD 0000, SUB 0001, AND 0010, ORR 0011, EOR 0100, MOV 0101, MUL 0110, UMULL 0111, SMULL 1000;
  - ResultSrc, ALUSrcA and ALUSrcB select constants.
- ALUControl codes must match the ALU's encoding.
- Sub-module: cond_unit (NZCV register plus CondEx logic).

Test Plan:
- ADD R1,R2,#5 (0xE2821005) after reset: states FETCH, DECODE, EXECUTEI, ALUWB, FETCH; RegWrite=1 only in ALUWB; ImmSrc=00.
- SUBS R0,R0,R0 then ADDEQ R3,R3,#1: Z latched to 1; ADDEQ asserts RegWrite in ALUWB. Repeat with ADDNE: RegWrite stays 0 through the whole sequence.
- LDR R4,[R5,#8] (0xE5954008): 5 states; AdrSrc=1 in MEMREAD; RegWrite+ResultSrc=01 in MEMWB. STR (0xE5854008): MemWrite=1 for exactly one cycle; RegSrc[1]=1 in DECODE.
- BNE with Z=1: PCWrite=0 in BRANCH. With Z=0: PCWrite=1, ResultSrc=10, RegSrc[0]=1.
- UMULL R2,R3,R4,R5 (0xE0832594): states MULEX, MULWBLO, MULWBHI; longFlag=1 only in MULWBLO; isMul=1 across all three; ALUControl=UMULL in MULEX.
- reset pulsed mid-MEMWRITE: MemWrite=0 in that cycle; FETCH next cycle; NZCV=0000.
